// File: rtl/pad_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pad_ctrl_pkg : config byte layout, mode/pull encodings, broadcast address |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package pad_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_IN    = 2'b01,
        MODE_OUT   = 2'b10,
        MODE_BIDIR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        PULL_NONE = 2'b00,
        PULL_UP   = 2'b01,
        PULL_DOWN = 2'b10,
        PULL_KEEP = 2'b11
    } pull_e;

    typedef struct packed {
        logic  deb;
        pull_e pull;
        logic  sl;
        logic  cs;
        logic  od;
        mode_e mode;
    } pad_cfg_t;

    // Truncated to the address width by the user; all-ones selects every pad.
    localparam logic [31:0] BROADCAST = 32'hFFFF_FFFF;

    // Open-drain outputs keep their receiver on so the core can read the wire back.
    function automatic logic cfg_ie(input pad_cfg_t c);
        return (c.mode == MODE_IN) || (c.mode == MODE_BIDIR) ||
               ((c.mode == MODE_OUT) && c.od);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pad_ctrl_in.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pad_ctrl_in : one pad's input synchroniser, debounce filter, edge detect |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module pad_ctrl_in #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_ie,
    input  logic i_deb_en,
    input  logic i_pad_in,
    output logic o_filt,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_samp;
    logic                   r_filt;
    logic                   r_prev;
    logic                   r_ie_prev;
    logic                   w_sync;
    logic                   w_filt;
    logic                   w_edge_ok;

    assign w_sync    = r_sync[SYNC_STAGES-1];
    assign w_filt    = i_ie & (i_deb_en ? r_filt : w_sync);
    assign w_edge_ok = (i_ie == r_ie_prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= '0;
            r_samp    <= 1'b0;
            r_filt    <= 1'b0;
            r_prev    <= 1'b0;
            r_ie_prev <= 1'b0;
        end else begin
            r_prev    <= w_filt;
            r_ie_prev <= i_ie;
            if (!i_ie) begin
                r_sync <= '0;
                r_samp <= 1'b0;
                r_filt <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad_in};
                if (i_tick) begin
                    r_samp <= w_sync;
                end
                // While bypassed, r_filt shadows the live value so re-enabling
                // the filter holds the current level instead of glitching.
                if (!i_deb_en) begin
                    r_filt <= w_sync;
                end else if (i_tick && (w_sync == r_samp)) begin
                    r_filt <= w_sync;
                end
            end
        end
    end

    assign o_filt = w_filt;
    assign o_rise = w_edge_ok &  w_filt & ~r_prev;
    assign o_fall = w_edge_ok & ~w_filt &  r_prev;

endmodule
`default_nettype wire

// File: rtl/pad_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pad_ctrl : per-pad config registers driving pad ring controls/input path |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module pad_ctrl
    import pad_ctrl_pkg::*;
#(
    parameter int          NUM_PADS    = 54,
    parameter int          SYNC_STAGES = 2,
    parameter int          DEBOUNCE_W  = 8,
    parameter logic [7:0]  RESET_CFG   = 8'h01,
    localparam int         AW          = $clog2(NUM_PADS + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_we_i,
    input  logic [AW-1:0]       cfg_addr_i,
    input  logic [7:0]          cfg_wdata_i,
    output logic [7:0]          cfg_rdata_o,
    input  logic [NUM_PADS-1:0] core_out_i,
    input  logic [NUM_PADS-1:0] core_oe_i,
    output logic [NUM_PADS-1:0] core_in_o,
    output logic [NUM_PADS-1:0] rise_o,
    output logic [NUM_PADS-1:0] fall_o,
    input  logic [NUM_PADS-1:0] pad_in_i,
    output logic [NUM_PADS-1:0] pad_out_o,
    output logic [NUM_PADS-1:0] pad_oe_o,
    output logic [NUM_PADS-1:0] pad_cs_o,
    output logic [NUM_PADS-1:0] pad_sl_o,
    output logic [NUM_PADS-1:0] pad_ie_o,
    output logic [NUM_PADS-1:0] pad_pu_o,
    output logic [NUM_PADS-1:0] pad_pd_o
);

    localparam logic [AW-1:0] c_bcast    = BROADCAST[AW-1:0];
    localparam logic [AW-1:0] c_num_pads = AW'(NUM_PADS);

    pad_cfg_t              r_cfg [NUM_PADS];
    logic [7:0]            r_rdata;
    logic [DEBOUNCE_W-1:0] r_presc;
    logic                  w_tick;
    logic                  w_addr_ok;
    logic                  w_addr_bc;

    assign w_tick    = &r_presc;
    assign w_addr_ok = (cfg_addr_i < c_num_pads);
    assign w_addr_bc = (cfg_addr_i == c_bcast);

    // Nonblocking read of r_cfg gives the pre-write value on a same-cycle access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                r_cfg[i] <= pad_cfg_t'(RESET_CFG);
            end
            r_rdata <= 8'h00;
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
            r_rdata <= w_addr_ok ? r_cfg[cfg_addr_i] : 8'h00;
            if (cfg_we_i) begin
                if (w_addr_ok) begin
                    r_cfg[cfg_addr_i] <= pad_cfg_t'(cfg_wdata_i);
                end else if (w_addr_bc) begin
                    for (int i = 0; i < NUM_PADS; i++) begin
                        r_cfg[i] <= pad_cfg_t'(cfg_wdata_i);
                    end
                end
            end
        end
    end

    assign cfg_rdata_o = r_rdata;

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
        pad_cfg_t w_c;
        logic     w_oe;

        assign w_c  = r_cfg[i];
        assign w_oe = (w_c.mode == MODE_OUT) | ((w_c.mode == MODE_BIDIR) & core_oe_i[i]);

        assign pad_ie_o[i]  = cfg_ie(w_c);
        assign pad_oe_o[i]  = w_c.od ? (w_oe & ~core_out_i[i]) : w_oe;
        assign pad_out_o[i] = w_c.od ? 1'b0 : core_out_i[i];
        assign pad_cs_o[i]  = w_c.cs;
        assign pad_sl_o[i]  = w_c.sl;
        // Keeper reinforces the last filtered level; pu and pd stay mutually exclusive.
        assign pad_pu_o[i]  = (w_c.pull == PULL_UP)   | ((w_c.pull == PULL_KEEP) &  core_in_o[i]);
        assign pad_pd_o[i]  = (w_c.pull == PULL_DOWN) | ((w_c.pull == PULL_KEEP) & ~core_in_o[i]);

        pad_ctrl_in #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_in (
            .clk      (clk_i),
            .rst      (rst_i),
            .i_tick   (w_tick),
            .i_ie     (pad_ie_o[i]),
            .i_deb_en (w_c.deb),
            .i_pad_in (pad_in_i[i]),
            .o_filt   (core_in_o[i]),
            .o_rise   (rise_o[i]),
            .o_fall   (fall_o[i])
        );
    end

endmodule
`default_nettype wire

// File: doc/pad_ctrl.md
# pad_ctrl

Parametrised pad-control block between the user core and the bidirectional pad ring. Each pad has a configuration byte, written through a simple address/data port, that sets direction mode, open-drain, drive strength, slew, pull/keeper and input debounce. The block drives the pad CS/SL/IE/PU/PD/OE/A controls and returns synchronised, optionally debounced pad inputs to the core, with per-pad edge pulses. It sits in `chip_top` between the core and the `bi_24t` pad generate loop.

## Interface
- NUM_PADS, 54, number of bidirectional pads
- SYNC_STAGES, 2, input synchroniser depth (≥2)
- DEBOUNCE_W, 8, debounce prescaler width; tick every 2^DEBOUNCE_W cycles
- RESET_CFG, 8'h01, per-pad config value loaded on reset
- AW, $clog2(NUM_PADS+1), config address width (localparam)

- clk_i  in  1  core clock
- rst_i  in  1  reset, synchronous, active-high
- cfg_we_i  in  1  config write strobe
- cfg_addr_i  in  AW  pad index; all-ones = broadcast
- cfg_wdata_i  in  8  config byte
- cfg_rdata_o  out  8  config of pad cfg_addr_i, registered
- core_out_i  in  NUM_PADS  core output data
- core_oe_i  in  NUM_PADS  core output enable (mode 11 only)
- core_in_o  out  NUM_PADS  filtered pad input
- rise_o / fall_o  out  NUM_PADS  one-cycle edge pulses
- pad_in_i  in  NUM_PADS  pad Y
- pad_out_o, pad_oe_o, pad_cs_o, pad_sl_o, pad_ie_o, pad_pu_o, pad_pd_o  out  NUM_PADS each  pad controls

## Operation
- Config byte: [1:0] mode (00 off, 01 input, 10 output, 11 core bidir); [2] open-drain; [3] CS; [4] SL; [6:5] pull (00 none, 01 up, 10 down, 11 keeper); [7] debounce enable.
- OE: off/input → 0; output → 1; bidir → core_oe_i. Open-drain: pad_out_o=0, pad_oe_o=OE & ~core_out_i; otherwise pad_out_o=core_out_i.
- IE = 1 for input and bidir; also for output when open-drain (readback). Off mode: IE=0, OE=0, pulls still honoured.
- Keeper: pu = core_in_o[i], pd = ~core_in_o[i]. Pull outputs are never both 1.
- Input path: SYNC_STAGES-flop sync; if IE=0, sync chain, filtered value forced to 0.
- Debounce: shared free-running DEBOUNCE_W-bit prescaler; on tick, sample sync output; filtered value updates only when two consecutive tick samples agree. Debounce off → filtered = sync output.
- Edges: compare filtered against its previous value; suppressed in any cycle where IE changed from its prior-cycle value.
- Writes: addr < NUM_PADS → that pad; all-ones → all pads; other → ignored. Read of out-of-range address returns 8'h00.

## Timing
- Reset: all configs = RESET_CFG; sync chains, filtered values, prescaler, cfg_rdata_o, rise_o, fall_o = 0. Pad controls are then the combinational result of RESET_CFG (default: IE=1, OE=0, no pulls).
- Pad control outputs combinational from config regs and core_*; a write at edge N takes effect after edge N.
- cfg_rdata_o: 1-cycle latency from cfg_addr_i; write and read of same pad in same cycle returns old value.
- Input latency, debounce off: SYNC_STAGES cycles to core_in_o; edge pulse same cycle core_in_o changes.
- Debounce on: change visible after second agreeing tick (≤2·2^DEBOUNCE_W + SYNC_STAGES cycles).
- Toggling debounce enable mid-stream: filtered value holds until next valid update; no spurious edge.
- Reset mid-operation overrides writes in the same cycle.

## Structure
- Package pad_ctrl_pkg: mode_e, pull_e enums, pad_cfg_t packed struct (bit layout above), BROADCAST constant.
- Sub-module pad_ctrl_in: one pad's sync + debounce + edge detect, instanced NUM_PADS times with shared tick.

## Test plan
- Reset, no writes → pad_ie_o all 1, pad_oe_o 0, pu/pd 0, cfg_rdata_o of pad 5 = 8'h01 after one cycle.
- Write pad 3 = 8'h06 (output, open-drain), core_out_i[3]=0 → pad_oe_o[3]=1, pad_out_o[3]=0; core_out_i[3]=1 → pad_oe_o[3]=0.
- Broadcast 8'h60 (keeper, off), then address NUM_PADS write ignored; pad_in high on pad 7 with IE=0 → core_in_o stays 0, pu[7]=0, pd[7]=1.
- Pad 0 input, no debounce, pad_in rises → core_in_o[0] high after 2 cycles, rise_o[0] single pulse.
- DEBOUNCE_W=2, debounce on, 3-cycle glitch → no change; 12-cycle level → update, one rise pulse.
- Switch pad 1 input→off while pad high → core_in_o drops to 0, no fall_o pulse.
